lfsr_stream: RTL

- Parametrised Fibonacci LFSR pseudo-random source with a valid/ready output stream.
- Emits one sample every SHIFTS shift steps.
- Supports seed load, run enable, zero-lock-up recovery and overrun flagging.
- Feeds test-pattern and noise consumers in the SDRAM image-processing path (frame fill, dither, memory test data).

---
 rtl/lfsr_pkg.sv | 50 +++++
 rtl/lfsr_core.sv | 41 ++++
 rtl/lfsr_stream.sv | 108 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default tap masks, recovery seed and the
// one-step Fibonacci update used by the core.
package lfsr_pkg;

  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_000F;

  // Left-shifting Fibonacci tap masks (bit i set = state[i] feeds the XOR)
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_13 = 32'h0000_100D;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400;
  localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_default_taps(input int width);
    logic [31:0] taps;
    case (width)
      8:       taps = LFSR_TAPS_8;
      13:      taps = LFSR_TAPS_13;
      16:      taps = LFSR_TAPS_16;
      24:      taps = LFSR_TAPS_24;
      32:      taps = LFSR_TAPS_32;
      default: taps = (32'd1 << (width - 1)) | 32'd1;
    endcase
    return taps;
  endfunction

  function automatic logic lfsr_parity(input logic [31:0] value);
    return ^value;
  endfunction

  // An all-zero result can only come from a degenerate tap mask; substitute the recovery seed.
  function automatic logic [31:0] lfsr_next(input logic [31:0] st, input logic [31:0] taps,
                                            input int width, input logic [31:0] recover);
    logic [31:0] mask;
    logic [31:0] nxt;
    if (width >= 32) begin
      mask = 32'hFFFF_FFFF;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    nxt = ((st << 1) | {31'd0, lfsr_parity(st & taps)}) & mask;
    if (nxt == 32'd0) begin
      nxt = recover & mask;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, shift and zero lock-up recovery.
// o_next is the post-shift value, used by the wrapper as the capture candidate.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int              WIDTH        = 13,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_shift,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;

  assign w_next  = WIDTH'(lfsr_next(32'(r_state), 32'(TAPS), WIDTH, 32'(DEFAULT_SEED)));
  assign w_seed  = (i_seed == {WIDTH{1'b0}}) ? DEFAULT_SEED : i_seed;
  assign o_state = r_state;
  assign o_next  = w_next;

  // State register: seed load wins over shifting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= DEFAULT_SEED;
    end else if (i_seed_load) begin
      r_state <= w_seed;
    end else if (i_shift) begin
      r_state <= w_next;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/lfsr_stream.sv
// Pseudo-random sample stream: every SHIFTS enabled shifts the LFSR value is
// offered on a valid/ready port; samples arriving while one is stalled are dropped and flagged.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 13,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter int               SHIFTS       = 13,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_DEFAULT_SEED),
  parameter int               CNT_W        = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rnd;
  logic             r_valid;
  logic             r_overrun;
  logic [WIDTH-1:0] w_next;
  logic             w_shift;
  logic             w_capture;
  logic             w_xfer;
  logic             w_accept;
  logic             w_drop;

  assign w_shift   = en & ~seed_load;
  assign w_capture = w_shift & (r_count == LAST_CNT);
  assign w_xfer    = r_valid & rnd_ready;
  assign w_accept  = w_capture & (~r_valid | rnd_ready);
  assign w_drop    = w_capture & r_valid & ~rnd_ready;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_seed_load (seed_load),
    .i_seed      (seed),
    .i_shift     (w_shift),
    .o_state     (state),
    .o_next      (w_next)
  );

  // Shift counter: restarts on seed load and after each capture, holds while disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (seed_load) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_capture) begin
      r_count <= {CNT_W{1'b0}};
    end else if (en) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // Output register and valid flag; a capture in the transfer cycle refills back-to-back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rnd   <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_rnd   <= w_next;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_rnd   <= r_rnd;
      r_valid <= 1'b0;
    end else begin
      r_rnd   <= r_rnd;
      r_valid <= r_valid;
    end
  end

  // Sticky overrun; a new drop outranks a clear in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign rnd       = r_rnd;
  assign rnd_valid = r_valid;
  assign overrun   = r_overrun;

endmodule
